// File: rtl/clock_reset_manager.sv
// Clock-enable generator and reset sequencer running entirely on CLK.
// Per-channel enables with run-time divisors, timed reset hold and single-step mode.
module clock_reset_manager #(
    parameter int          NCH      = 2,
    parameter int          DIVW     = 16,
    parameter int unsigned DIV_INIT = 0,
    parameter int          HOLD_W   = 16
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            soft_rst,
    input  logic            div_wr,
    input  logic [2:0]      div_ch,
    input  logic [DIVW-1:0] div_data,
    input  logic            step_mode,
    input  logic            step_req,
    output logic            resetn,
    output logic [NCH-1:0]  ce,
    output logic [1:0]      state
);

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } st_t;

    st_t st_q, st_d;

    logic [1:0]        rst_sync;
    logic [1:0]        mode_sync;
    logic [2:0]        req_sync;
    logic [HOLD_W-1:0] hold_cnt;
    logic              hold_done;
    logic              step_mode_s;
    logic              step_rise;
    logic              run_go;
    logic              step_go;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            rst_sync  <= '0;
            mode_sync <= '0;
            req_sync  <= '0;
        end else begin
            rst_sync  <= {rst_sync[0], 1'b1};
            mode_sync <= {mode_sync[0], step_mode};
            req_sync  <= {req_sync[1:0], step_req};
        end
    end

    assign step_mode_s = mode_sync[1];
    // req_sync[2] is the previous synchronised value, giving a clean edge detect
    assign step_rise   = req_sync[1] & ~req_sync[2];

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            hold_cnt <= '0;
        end else if (soft_rst) begin
            hold_cnt <= '0;
        end else if (rst_sync[1] && !hold_done) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    assign hold_done = &hold_cnt;
    assign resetn    = hold_done;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            st_q <= HOLD;
        end else begin
            st_q <= st_d;
        end
    end

    always_comb begin
        st_d = st_q;
        if (soft_rst) begin
            st_d = HOLD;
        end else begin
            unique case (st_q)
                HOLD: if (hold_done) st_d = step_mode_s ? STEP : RUN;
                RUN:  if (step_mode_s) st_d = STEP;
                STEP: if (!step_mode_s) st_d = RUN;
                default: st_d = HOLD;
            endcase
        end
    end

    assign state   = st_q;
    assign run_go  = (st_q == RUN) && (st_d == RUN);
    assign step_go = (st_q == STEP) && (st_d == STEP);

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic [DIVW-1:0] div_q;
        logic [DIVW-1:0] pend_q;
        logic [DIVW-1:0] cnt_q;
        logic            pend_v;
        logic            ce_q;
        logic            wr_hit;
        logic            wrap;
        logic            apply;

        assign wr_hit = div_wr && (div_ch == 3'(g));
        assign wrap   = (cnt_q == div_q);
        // In RUN a new divisor only lands on a wrap so no period is cut short
        assign apply  = pend_v && (run_go ? wrap : (st_q != RUN));

        always_ff @(posedge CLK or negedge RESET) begin
            if (!RESET) begin
                div_q  <= DIVW'(DIV_INIT);
                pend_q <= '0;
                pend_v <= 1'b0;
                cnt_q  <= '0;
                ce_q   <= 1'b0;
            end else begin
                if (apply) div_q <= pend_q;
                if (wr_hit) begin
                    pend_q <= div_data;
                    pend_v <= 1'b1;
                end else if (apply) begin
                    pend_v <= 1'b0;
                end
                if (run_go) begin
                    cnt_q <= wrap ? '0 : cnt_q + 1'b1;
                    ce_q  <= wrap;
                end else begin
                    cnt_q <= '0;
                    ce_q  <= step_go & step_rise;
                end
            end
        end

        assign ce[g] = ce_q & resetn;
    end

endmodule

// File: tb/tb_clock_reset_manager.sv
// Bench for clock_reset_manager: event-time reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_clock_reset_manager;

    localparam int NCH    = 2;
    localparam int DIVW   = 16;
    localparam int HOLD_W = 4;
    localparam int HMAX   = (1 << HOLD_W) - 1;

    logic            CLK;
    logic            RESET;
    logic            soft_rst;
    logic            div_wr;
    logic [2:0]      div_ch;
    logic [DIVW-1:0] div_data;
    logic            step_mode;
    logic            step_req;
    logic            resetn;
    logic [NCH-1:0]  ce;
    logic [1:0]      state;

    int checks   = 0;
    int failures = 0;

    clock_reset_manager #(
        .NCH(NCH), .DIVW(DIVW), .DIV_INIT(0), .HOLD_W(HOLD_W)
    ) dut (
        .CLK(CLK), .RESET(RESET), .soft_rst(soft_rst),
        .div_wr(div_wr), .div_ch(div_ch), .div_data(div_data),
        .step_mode(step_mode), .step_req(step_req),
        .resetn(resetn), .ce(ce), .state(state)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: hold length, mode and next-fire times per channel
    longint t_edge = 0;
    int     rel    = 0;
    int     hold_n = 0;
    int     m_st   = 0;
    bit     sm_h[3];
    bit     rq_h[4];
    int     m_div[NCH];
    int     m_pend[NCH];
    bit     m_pv[NCH];
    bit     m_ce[NCH];
    longint fire[NCH];

    always @(posedge CLK or negedge RESET) begin
        int  old_st;
        int  new_st;
        bit  sm_s;
        bit  rise;
        bit  ap;
        if (!RESET) begin
            rel = 0;
            hold_n = 0;
            m_st = 0;
            for (int k = 0; k < 3; k++) sm_h[k] = 1'b0;
            for (int k = 0; k < 4; k++) rq_h[k] = 1'b0;
            for (int i = 0; i < NCH; i++) begin
                m_div[i] = 0;
                m_pend[i] = 0;
                m_pv[i] = 1'b0;
                m_ce[i] = 1'b0;
                fire[i] = 0;
            end
        end else begin
            t_edge++;
            old_st = m_st;
            sm_s = sm_h[1];
            rise = rq_h[1] && !rq_h[2];
            if (soft_rst) new_st = 0;
            else if (old_st == 0) new_st = (hold_n == HMAX) ? (sm_s ? 2 : 1) : 0;
            else new_st = sm_s ? 2 : 1;
            if (soft_rst) hold_n = 0;
            else if (rel >= 2 && hold_n < HMAX) hold_n++;
            for (int i = 0; i < NCH; i++) begin
                ap = 1'b0;
                if (old_st == 1 && new_st == 1) begin
                    if (t_edge == fire[i]) begin
                        m_ce[i] = 1'b1;
                        if (m_pv[i]) begin
                            m_div[i] = m_pend[i];
                            ap = 1'b1;
                        end
                        fire[i] = t_edge + m_div[i] + 1;
                    end else begin
                        m_ce[i] = 1'b0;
                    end
                end else begin
                    m_ce[i] = (old_st == 2 && new_st == 2 && rise);
                    if (old_st != 1 && m_pv[i]) begin
                        m_div[i] = m_pend[i];
                        ap = 1'b1;
                    end
                    fire[i] = t_edge + m_div[i] + 1;
                end
                if (ap) m_pv[i] = 1'b0;
                if (div_wr && int'(div_ch) == i) begin
                    m_pend[i] = int'(div_data);
                    m_pv[i] = 1'b1;
                end
            end
            for (int k = 2; k > 0; k--) sm_h[k] = sm_h[k-1];
            sm_h[0] = step_mode;
            for (int k = 3; k > 0; k--) rq_h[k] = rq_h[k-1];
            rq_h[0] = step_req;
            m_st = new_st;
            if (rel < 1000) rel++;
        end
    end

    always @(negedge CLK) begin
        logic           e_rn;
        logic [NCH-1:0] e_ce;
        e_rn = (hold_n == HMAX);
        for (int i = 0; i < NCH; i++) e_ce[i] = m_ce[i] & e_rn;
        chk("model_resetn", int'(resetn), int'(e_rn));
        chk("model_ce", int'(ce), int'(e_ce));
        chk("model_state", int'(state), m_st);
    end

    task automatic wr(input int ch, input int d);
        @(posedge CLK);
        #2;
        div_wr = 1'b1;
        div_ch = 3'(ch);
        div_data = DIVW'(d);
        @(posedge CLK);
        #2;
        div_wr = 1'b0;
    endtask

    task automatic count_ce(input int n, output int n0, output int n1);
        n0 = 0;
        n1 = 0;
        repeat (n) begin
            @(negedge CLK);
            n0 += int'(ce[0]);
            n1 += int'(ce[1]);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n0, n1, err, k;
        bit exp;
        RESET = 1'b0;
        soft_rst = 1'b0;
        div_wr = 1'b0;
        div_ch = '0;
        div_data = '0;
        step_mode = 1'b0;
        step_req = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_resetn", int'(resetn), 0);
        chk("rst_ce", int'(ce), 0);
        chk("rst_state", int'(state), 0);

        // Release, stage div1=3 during the hold (write sampled on edge 2)
        @(posedge CLK);
        #2 RESET = 1'b1;
        wr(1, 3);
        repeat (14) @(posedge CLK);
        @(negedge CLK);
        chk("hold_edge16", int'(resetn), 0);
        @(posedge CLK);
        @(negedge CLK);
        chk("hold_edge17", int'(resetn), 1);
        chk("hold_state17", int'(state), 0);
        @(posedge CLK);
        @(negedge CLK);
        chk("run_entry", int'(state), 1);

        err = 0;
        for (int j = 1; j <= 8; j++) begin
            @(negedge CLK);
            exp = (j == 4 || j == 8);
            if (ce[1] !== exp || ce[0] !== 1'b1) err++;
        end
        chk("first_fire_pattern", err, 0);
        count_ce(40, n0, n1);
        chk("div0_count", n0, 40);
        chk("div3_count", n1, 10);

        // Mid-period writes: 1 then 7, only 7 should ever take effect
        k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while (ce[1] !== 1'b1 && k < 50);
        chk("wait_ce1_timeout", int'(k >= 50), 0);
        err = 0;
        for (int j = 1; j <= 20; j++) begin
            @(posedge CLK);
            #2;
            if (j == 1) begin
                div_wr = 1'b1;
                div_ch = 3'd1;
                div_data = 16'd1;
            end else if (j == 2) begin
                div_data = 16'd7;
            end else begin
                div_wr = 1'b0;
            end
            @(negedge CLK);
            exp = (j == 4 || j == 12 || j == 20);
            if (ce[1] !== exp) err++;
        end
        chk("last_write_wins", err, 0);

        // Out-of-range channel is ignored
        @(posedge CLK);
        #2;
        div_wr = 1'b1;
        div_ch = 3'd5;
        div_data = 16'd0;
        @(posedge CLK);
        #2 div_wr = 1'b0;
        count_ce(32, n0, n1);
        chk("badch_ce0", n0, 32);
        chk("badch_ce1", n1, 4);

        // Single-step mode
        @(posedge CLK);
        #2 step_mode = 1'b1;
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        chk("step_state", int'(state), 2);
        err = 0;
        n0 = 0;
        for (int j = 0; j < 30; j++) begin
            @(posedge CLK);
            #2 step_req = ((j % 10) < 3);
            @(negedge CLK);
            exp = (j == 3 || j == 13 || j == 23);
            if (ce !== (exp ? 2'b11 : 2'b00)) err++;
            if (ce == 2'b11) n0++;
        end
        chk("step_pulse_timing", err, 0);
        chk("step_pulse_count", n0, 3);
        @(posedge CLK);
        #2 step_mode = 1'b0;
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        chk("back_to_run", int'(state), 1);

        // Soft reset keeps divisors
        @(posedge CLK);
        #2 soft_rst = 1'b1;
        @(posedge CLK);
        #2 soft_rst = 1'b0;
        @(negedge CLK);
        chk("soft_resetn", int'(resetn), 0);
        chk("soft_state", int'(state), 0);
        repeat (14) @(posedge CLK);
        @(negedge CLK);
        chk("soft_hold15", int'(resetn), 0);
        @(posedge CLK);
        @(negedge CLK);
        chk("soft_release", int'(resetn), 1);
        repeat (3) @(posedge CLK);
        count_ce(32, n0, n1);
        chk("soft_keep_ce0", n0, 32);
        chk("soft_keep_ce1", n1, 4);

        // RESET during the hold restarts everything and reloads divisors
        @(posedge CLK);
        #2 soft_rst = 1'b1;
        @(posedge CLK);
        #2 soft_rst = 1'b0;
        repeat (5) @(posedge CLK);
        #2 RESET = 1'b0;
        @(negedge CLK);
        chk("hard_resetn", int'(resetn), 0);
        repeat (2) @(posedge CLK);
        #2 RESET = 1'b1;
        repeat (16) @(posedge CLK);
        @(negedge CLK);
        chk("hard_hold16", int'(resetn), 0);
        @(posedge CLK);
        @(negedge CLK);
        chk("hard_release", int'(resetn), 1);
        repeat (2) @(posedge CLK);
        count_ce(20, n0, n1);
        chk("init_div_ce0", n0, 20);
        chk("init_div_ce1", n1, 20);

        // Randomized traffic against the model
        for (int j = 0; j < 3000; j++) begin
            @(posedge CLK);
            #2;
            div_wr = ($urandom_range(0, 7) == 0);
            div_ch = 3'($urandom_range(0, 3));
            div_data = DIVW'($urandom_range(0, 6));
            if ($urandom_range(0, 59) == 0) step_mode = ~step_mode;
            if ($urandom_range(0, 3) == 0) step_req = ~step_req;
            soft_rst = ($urandom_range(0, 299) == 0);
            RESET = ($urandom_range(0, 699) != 0);
        end
        @(posedge CLK);
        #2;
        RESET = 1'b1;
        soft_rst = 1'b0;
        div_wr = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
